// File: rtl/fullchip_pkg.sv
// Shared encodings for the fullchip inst/mem_in sequencer: instruction bit map,
// sequencer state encoding and counter width.
package fullchip_pkg;

  localparam int unsigned INST_W = 17;

  localparam int unsigned INST_OFIFO_RD   = 16;
  localparam int unsigned INST_QK_ADD_LO  = 12;
  localparam int unsigned INST_PMEM_ADD_LO = 8;
  localparam int unsigned INST_EXECUTE    = 7;
  localparam int unsigned INST_LOAD       = 6;
  localparam int unsigned INST_QMEM_RD    = 5;
  localparam int unsigned INST_QMEM_WR    = 4;
  localparam int unsigned INST_KMEM_RD    = 3;
  localparam int unsigned INST_KMEM_WR    = 2;
  localparam int unsigned INST_PMEM_RD    = 1;
  localparam int unsigned INST_PMEM_WR    = 0;

  localparam int unsigned SEQ_CNT_W = 8;

  typedef enum logic [3:0] {
    IDLE, QWR, QEND, KWR, KEND, GAP2, LOAD, LDTAIL,
    LDOFF, WAIT1, EXEC, EXTAIL, WAIT2, OFIFO, PRD, DONE
  } seq_state_t;

endpackage

// File: rtl/fullchip_inst_seq_phase_cnt.sv
// seq_phase_cnt: loadable up-counter with terminal-count flag, used for the
// per-phase index and gap timing of the sequencer.
module seq_phase_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/fullchip_inst_seq.sv
// fullchip_inst_seq: autonomous initiator producing the 17-bit inst word and mem_in
// bus for fullchip. Optional perf counters are built when SEQ_PERF_EN is defined.
module fullchip_inst_seq
  import fullchip_pkg::*;
#(
  parameter int unsigned bw          = 8,
  parameter int unsigned pr          = 8,
  parameter int unsigned col         = 8,
  parameter int unsigned total_cycle = 8,
  parameter int unsigned gap_cycles  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [pr*bw-1:0]  host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [pr*bw-1:0]  mem_in,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles,
  output logic [15:0]       stall_cycles
`endif
);

  seq_state_t           state, state_nxt;
  logic [INST_W-1:0]    inst_nxt;
  logic [SEQ_CNT_W-1:0] cnt, term;
  logic                 cnt_tc, cnt_load, cnt_en, advance, accept;
  logic [3:0]           idx;

  assign accept = host_ready && host_valid;
  assign idx    = cnt[3:0];

  seq_phase_cnt #(.W(SEQ_CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .term     (term),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // inst is registered from the current state, so each phase's word appears one
  // cycle after the state is entered; the counter restarts at 0 on every transition.
  always_comb begin
    state_nxt = state;
    inst_nxt  = '0;
    term      = '0;
    advance   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = QWR;
      QWR: begin
        term = SEQ_CNT_W'(total_cycle - 1);
        advance = accept;
        inst_nxt[INST_QMEM_WR] = accept;
        inst_nxt[INST_QK_ADD_LO +: 4] = accept ? idx : inst[INST_QK_ADD_LO +: 4];
        if (accept && cnt_tc) state_nxt = QEND;
      end
      QEND: state_nxt = KWR;
      KWR: begin
        term = SEQ_CNT_W'(col - 1);
        advance = accept;
        inst_nxt[INST_KMEM_WR] = accept;
        inst_nxt[INST_QK_ADD_LO +: 4] = accept ? idx : inst[INST_QK_ADD_LO +: 4];
        if (accept && cnt_tc) state_nxt = KEND;
      end
      KEND: state_nxt = GAP2;
      GAP2: begin
        term = SEQ_CNT_W'(1);
        advance = 1'b1;
        if (cnt_tc) state_nxt = LOAD;
      end
      LOAD: begin
        term = SEQ_CNT_W'(col + 1);
        advance = 1'b1;
        inst_nxt[INST_LOAD]   = 1'b1;
        inst_nxt[INST_KMEM_RD] = (cnt != '0);
        inst_nxt[INST_QK_ADD_LO +: 4] = (cnt == '0) ? 4'd0 : idx - 4'd1;
        if (cnt_tc) state_nxt = LDTAIL;
      end
      LDTAIL: begin
        inst_nxt[INST_LOAD] = 1'b1;
        state_nxt = LDOFF;
      end
      LDOFF: state_nxt = WAIT1;
      WAIT1: begin
        term = SEQ_CNT_W'(gap_cycles - 1);
        advance = 1'b1;
        if (cnt_tc) state_nxt = EXEC;
      end
      EXEC: begin
        term = SEQ_CNT_W'(total_cycle);
        advance = 1'b1;
        inst_nxt[INST_EXECUTE] = 1'b1;
        inst_nxt[INST_QMEM_RD] = 1'b1;
        inst_nxt[INST_QK_ADD_LO +: 4] = idx;
        if (cnt_tc) state_nxt = EXTAIL;
      end
      EXTAIL: state_nxt = WAIT2;
      WAIT2: begin
        term = SEQ_CNT_W'(gap_cycles - 1);
        advance = 1'b1;
        if (cnt_tc) state_nxt = OFIFO;
      end
      OFIFO: begin
        term = SEQ_CNT_W'(total_cycle - 1);
        advance = 1'b1;
        inst_nxt[INST_OFIFO_RD] = 1'b1;
        inst_nxt[INST_PMEM_WR]  = 1'b1;
        inst_nxt[INST_PMEM_ADD_LO +: 4] = idx;
        if (cnt_tc) state_nxt = PRD;
      end
      PRD: begin
        term = SEQ_CNT_W'(total_cycle);
        advance = 1'b1;
        inst_nxt[INST_PMEM_RD] = 1'b1;
        inst_nxt[INST_PMEM_ADD_LO +: 4] = idx;
        if (cnt_tc) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cnt_load = (state_nxt != state);
    cnt_en   = advance && !cnt_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      inst       <= '0;
      mem_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      inst       <= inst_nxt;
      if (accept) mem_in <= host_data;
      busy       <= (state_nxt != IDLE);
      done       <= (state == DONE);
      host_ready <= (state_nxt == QWR) || (state_nxt == KWR);
    end
  end

`ifdef SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 16'd1;
      if (host_ready && !host_valid && stall_cycles != '1)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
